// File: rtl/counter_pkg.sv
// Shared definitions for the wrapping up/down counter: default parameter
// values and the direction encoding of the up input.
package counter_pkg;

  localparam int DEF_MIN   = 0;
  localparam int DEF_MAX   = 31;
  localparam int DEF_WIDTH = 5;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/counter_if.sv
// Control/status bundle for the counter: the driver supplies direction and
// enable, the counter returns its registered count.
interface counter_if
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic clk
);

  logic             up;
  logic             enable;
  logic [WIDTH-1:0] count;

  modport master (
    input  clk,
    output up,
    output enable,
    input  count
  );

  modport slave (
    input  clk,
    input  up,
    input  enable,
    output count
  );

endinterface

// File: rtl/counter.sv
// Wrapping up/down counter over the closed range [MIN, MAX].
// The count is a plain register; the next value is chosen by comparing the
// current value against the range ends before any add/subtract, so the
// arithmetic never relies on modular overflow.
module counter
  import counter_pkg::*;
#(
  parameter int MIN   = DEF_MIN,
  parameter int MAX   = DEF_MAX,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  localparam longint TOP_CODE = (longint'(1) << WIDTH) - 1;

  // Reject ranges that are empty, inverted or do not fit in WIDTH bits.
  if (!((WIDTH > 0) && (WIDTH < 32) && (MIN >= 0) && (MIN < MAX) &&
        (longint'(MAX) <= TOP_CODE))) begin : g_bad_params
    $error("counter: parameters must satisfy 0 <= MIN < MAX <= 2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  logic [WIDTH-1:0] cnt_p0;
  logic [WIDTH-1:0] cnt_nxt;
  logic             below_min;
  logic             above_max;

  // When a range end coincides with the end of the code space the
  // out-of-range test on that side cannot be true, so it is tied off.
  if (MIN == 0) begin : g_no_low_check
    assign below_min = 1'b0;
  end else begin : g_low_check
    assign below_min = (cnt_p0 < MIN_V);
  end

  if (longint'(MAX) == TOP_CODE) begin : g_no_high_check
    assign above_max = 1'b0;
  end else begin : g_high_check
    assign above_max = (cnt_p0 > MAX_V);
  end

  // Successor of a value when moving one step in the given direction.
  function automatic logic [WIDTH-1:0] step_count(
    input logic [WIDTH-1:0] cur,
    input dir_e             dir
  );
    logic [WIDTH-1:0] res;
    if (dir == DIR_UP) begin
      res = (cur == MAX_V) ? MIN_V : (cur + ONE_V);
    end else begin
      res = (cur == MIN_V) ? MAX_V : (cur - ONE_V);
    end
    return res;
  endfunction

  // Next-state selection: hold, recover from an illegal value, or step.
  always_comb begin
    cnt_nxt = cnt_p0;
    if (enable) begin
      if (below_min || above_max) begin
        cnt_nxt = MIN_V;
      end else begin
        cnt_nxt = step_count(cnt_p0, dir_e'(up));
      end
    end
  end

  // Count register; reset forces MIN regardless of enable and direction.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_p0 <= MIN_V;
    end else begin
      cnt_p0 <= cnt_nxt;
    end
  end

  assign count = cnt_p0;

endmodule

// File: tb/tb_counter.sv
// Directed bench for the wrapping counter with MIN=3, MAX=27, WIDTH=5.
// A vector table covers reset and the wrap points; hand-written sequences
// cover the long counting runs. An independent reference model is checked
// on every edge along with a range check.
module tb_counter;

  localparam int MIN   = 3;
  localparam int MAX   = 27;
  localparam int WIDTH = 5;

  logic clk;
  logic reset;

  int total;
  int bad;
  int mref;

  counter_if #(.WIDTH(WIDTH)) cif (.clk(clk));

  counter #(
    .MIN  (MIN),
    .MAX  (MAX),
    .WIDTH(WIDTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .up    (cif.up),
    .enable(cif.enable),
    .count (cif.count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic r;
    logic u;
    logic e;
    int   exp;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one edge's inputs, advance the model, and check after the edge.
  task automatic step(input logic r, input logic u, input logic e);
    @(negedge clk);
    reset      = r;
    cif.up     = u;
    cif.enable = e;
    @(posedge clk);
    if (r) begin
      mref = MIN;
    end else if (e) begin
      if (mref < MIN || mref > MAX) mref = MIN;
      else if (u) mref = (mref == MAX) ? MIN : mref + 1;
      else        mref = (mref == MIN) ? MAX : mref - 1;
    end
    #1;
    check("scoreboard", int'(cif.count), mref);
    total++;
    if (int'(cif.count) < MIN || int'(cif.count) > MAX) begin
      bad++;
      $display("FAIL range: got %0d, expected within [%0d,%0d]", cif.count, MIN, MAX);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    mref       = MIN;
    reset      = 1'b1;
    cif.up     = 1'b0;
    cif.enable = 1'b0;

    vecs[0]  = '{1'b1, 1'b1, 1'b1, 3};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 3};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 4};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 3};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 27};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 26};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 27};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 3};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 3};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 3};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 3};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 4};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 3};

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].r, vecs[i].u, vecs[i].e);
      check($sformatf("vec%0d", i), int'(cif.count), vecs[i].exp);
    end

    // Two reset edges, then a full climb to MAX and the wrap to MIN.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("reset_two_edges", int'(cif.count), 3);
    for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 1'b1);
    check("climb_to_max", int'(cif.count), 27);
    step(1'b0, 1'b1, 1'b1);
    check("wrap_up", int'(cif.count), 3);

    // 38 up edges from 3 pass through one wrap and land on 16.
    for (int i = 0; i < 38; i++) step(1'b0, 1'b1, 1'b1);
    check("up_38", int'(cif.count), 16);

    // Disabled for 40 edges while up toggles: value must hold.
    for (int i = 0; i < 40; i++) step(1'b0, logic'(i % 2), 1'b0);
    check("hold_40", int'(cif.count), 16);

    // Count down to MIN, wrap to MAX, then continue down.
    for (int i = 0; i < 13; i++) step(1'b0, 1'b0, 1'b1);
    check("down_to_min", int'(cif.count), 3);
    step(1'b0, 1'b0, 1'b1);
    check("wrap_down", int'(cif.count), 27);
    step(1'b0, 1'b0, 1'b1);
    check("after_wrap_down", int'(cif.count), 26);

    // From 26 down to 20, then a one-edge reset while enabled.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1);
    check("reach_20", int'(cif.count), 20);
    step(1'b1, 1'b1, 1'b1);
    check("reset_mid_count", int'(cif.count), 3);
    step(1'b0, 1'b1, 1'b1);
    check("resume_after_reset", int'(cif.count), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
